// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator with a shared period counter, per-channel
// clamped targets, per-period slew limiting and feedback pulse-width capture.
module servo_pwm_array #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 20,
  parameter int PERIOD    = 1000000,
  parameter int MIN_PULSE = 50000,
  parameter int MAX_PULSE = 100000,
  parameter int STEP      = 500
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_CH)+1:0]   address,
  input  logic                        chipselect,
  input  logic                        read,
  input  logic                        write,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  input  logic [NUM_CH-1:0]           pwm_response,
  output logic [NUM_CH-1:0]           pwm_out
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic [CNT_W-1:0] width_t;

  localparam width_t         MIN_W  = width_t'(MIN_PULSE);
  localparam width_t         MAX_W  = width_t'(MAX_PULSE);
  localparam width_t         STEP_W = width_t'(STEP);
  localparam logic [CNT_W:0] STEP_D = (CNT_W+1)'(STEP);

  width_t cnt;
  width_t target       [NUM_CH];
  width_t current      [NUM_CH];
  width_t measured     [NUM_CH];
  width_t meas_cnt     [NUM_CH];
  width_t next_current [NUM_CH];

  logic [NUM_CH-1:0] enable, en_act, valid, overrun;
  logic [NUM_CH-1:0] sync1, sync2, resp_prev;

  logic [CHW-1:0] ch;
  logic [1:0]     regsel;
  logic           ch_ok, wr_en, rd_en, boundary;
  width_t         wr_target;
  logic [31:0]    rd_mux;

  assign ch       = CHW'(address >> 2);
  assign regsel   = address[1:0];
  assign ch_ok    = (32'(ch) < 32'(NUM_CH));
  assign wr_en    = chipselect & write & ch_ok;
  assign rd_en    = chipselect & read;
  assign boundary = (cnt == width_t'(PERIOD - 1));

  // Clamp compares the whole bus word so oversized values pin to MAX_PULSE.
  always_comb begin
    wr_target = writedata[CNT_W-1:0];
    if (writedata < 32'(MIN_PULSE))
      wr_target = MIN_W;
    else if (writedata > 32'(MAX_PULSE))
      wr_target = MAX_W;
  end

  always_comb begin
    logic [CNT_W:0] d, mag;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      next_current[c] = target[c];
      d   = {1'b0, target[c]} - {1'b0, current[c]};
      mag = d[CNT_W] ? -d : d;
      if (enable[c] && en_act[c] && STEP != 0 && mag > STEP_D)
        next_current[c] = d[CNT_W] ? current[c] - STEP_W : current[c] + STEP_W;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (ch_ok) begin
      case (regsel)
        2'd0: rd_mux = 32'(target[ch]);
        2'd1: rd_mux = 32'(current[ch]);
        2'd2: rd_mux = 32'(measured[ch]);
        2'd3: rd_mux = {29'b0, overrun[ch], valid[ch], enable[ch]};
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      readdata  <= '0;
      pwm_out   <= '0;
      enable    <= '0;
      en_act    <= '0;
      valid     <= '0;
      overrun   <= '0;
      sync1     <= '0;
      sync2     <= '0;
      resp_prev <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        target[c]   <= MIN_W;
        current[c]  <= MIN_W;
        measured[c] <= '0;
        meas_cnt[c] <= '0;
      end
    end else begin
      cnt <= boundary ? '0 : cnt + 1'b1;

      for (int unsigned c = 0; c < NUM_CH; c++)
        pwm_out[c] <= en_act[c] && (cnt < current[c]);

      if (boundary) begin
        en_act <= enable;
        for (int unsigned c = 0; c < NUM_CH; c++)
          current[c] <= next_current[c];
      end

      sync1     <= pwm_response;
      sync2     <= sync1;
      resp_prev <= sync2;

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (sync2[c] && !resp_prev[c])
          meas_cnt[c] <= width_t'(1);
        else if (sync2[c] && meas_cnt[c] != '1)
          meas_cnt[c] <= meas_cnt[c] + 1'b1;
      end

      if (rd_en) begin
        readdata <= rd_mux;
        if (ch_ok && regsel == 2'd2)
          valid[ch] <= 1'b0;
      end

      if (wr_en) begin
        case (regsel)
          2'd0: target[ch] <= wr_target;
          2'd3: begin
            enable[ch] <= writedata[0];
            if (writedata[2])
              overrun[ch] <= 1'b0;
          end
          default: ;
        endcase
      end

      // Capture is last so it beats a same-cycle MEASURED read or RW1C clear.
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!sync2[c] && resp_prev[c]) begin
          measured[c] <= meas_cnt[c];
          valid[c]    <= 1'b1;
          if (valid[c])
            overrun[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array: period-level model of the PWM outputs checked every
// cycle, plus directed register reads with hand-computed values.
module tb_servo_pwm_array;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 20;
  localparam int PERIOD = 100;
  localparam int MIN_P  = 10;
  localparam int MAX_P  = 50;
  localparam int STEP   = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  pwm_response = '0;
  logic [3:0]  pwm_out;

  always #5 clk = ~clk;

  servo_pwm_array #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD),
    .MIN_PULSE(MIN_P), .MAX_PULSE(MAX_P), .STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .pwm_response(pwm_response), .pwm_out(pwm_out)
  );

  int passes = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int clampw(input logic [31:0] v);
    if (v < MIN_P) return MIN_P;
    if (v > MAX_P) return MAX_P;
    return int'(v);
  endfunction

  // Model: k counts clocks since reset; each PERIOD-long window has one width
  // and one on/off decision, fixed from the registers just before it starts.
  int       k;
  int       m_target [NUM_CH];
  bit       m_enable [NUM_CH];
  int       m_w      [NUM_CH];
  bit       m_on     [NUM_CH];
  int       m_ph, m_diff, m_c;
  logic [3:0] exp_pwm = '0;

  always @(posedge clk) begin
    if (reset) begin
      k = 0;
      exp_pwm = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_target[c] = MIN_P; m_enable[c] = 1'b0; m_w[c] = MIN_P; m_on[c] = 1'b0;
      end
    end else begin
      m_ph = k % PERIOD;
      for (int c = 0; c < NUM_CH; c++) exp_pwm[c] = m_on[c] && (m_ph < m_w[c]);
      if (m_ph == PERIOD - 1) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (m_enable[c] && m_on[c]) begin
            m_diff = m_target[c] - m_w[c];
            if (m_diff > STEP) m_w[c] = m_w[c] + STEP;
            else if (m_diff < -STEP) m_w[c] = m_w[c] - STEP;
            else m_w[c] = m_target[c];
          end else begin
            m_w[c] = m_target[c];
          end
          m_on[c] = m_enable[c];
        end
      end
      if (chipselect && write) begin
        m_c = int'(address[3:2]);
        if (address[1:0] == 2'd0) m_target[m_c] = clampw(writedata);
        if (address[1:0] == 2'd3) m_enable[m_c] = writedata[0];
      end
      k++;
    end
  end

  always @(negedge clk) check("pwm_out", {28'b0, pwm_out}, {28'b0, exp_pwm});

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    @(negedge clk);
    address = 4'(ch * 4 + rg); chipselect = 1'b1; write = 1'b1; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input int ch, input int rg, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = 4'(ch * 4 + rg); chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check(name, readdata, exp);
  endtask

  task automatic rw(input int ch, input int rg, input logic [31:0] d, input logic [31:0] exp,
                    input string name);
    @(negedge clk);
    address = 4'(ch * 4 + rg); chipselect = 1'b1; read = 1'b1; write = 1'b1; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    check(name, readdata, exp);
  endtask

  // Wait until the sample just taken is the last clock of a period.
  task automatic align();
    int n;
    n = 0;
    while (k % PERIOD != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL align: period start not seen within %0d cycles, expected < 300", n);
    end
  endtask

  // Leaves the bench just after the first sample of a fresh period.
  task automatic settle();
    @(negedge clk);
    align();
    @(negedge clk);
  endtask

  task automatic measure(input int ch, output int hi);
    align();
    hi = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      hi += int'(pwm_out[ch]);
    end
  endtask

  task automatic pulse(input int ch, input int n);
    @(negedge clk);
    pwm_response[ch] = 1'b1;
    repeat (n) @(negedge clk);
    pwm_response[ch] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int hi;
  int exp_slew [4] = '{35, 40, 45, 45};

  initial begin
    repeat (3) @(negedge clk);
    check("readdata_reset", readdata, 32'd0);
    check("pwm_reset", {28'b0, pwm_out}, 32'd0);
    reset = 1'b0;
    rd(0, 0, 32'd10, "target0_reset");
    rd(0, 3, 32'd0, "ctrl0_reset");

    wr(1, 0, 32'd200);
    rd(1, 0, 32'd50, "target_clamp_hi");
    wr(1, 0, 32'd5);
    rd(1, 0, 32'd10, "target_clamp_lo");
    wr(1, 0, 32'd30);
    wr(1, 3, 32'd1);
    settle();
    measure(1, hi); check("width_30_a", hi, 32'd30);
    measure(1, hi); check("width_30_b", hi, 32'd30);

    settle();
    wr(1, 0, 32'd45);
    for (int i = 0; i < 4; i++) begin
      measure(1, hi);
      check($sformatf("slew_period_%0d", i), hi, exp_slew[i]);
    end
    check("model_w1_45", m_w[1], 32'd45);
    settle();
    wr(1, 0, 32'd42);
    measure(1, hi); check("slew_small_step", hi, 32'd42);
    rd(1, 1, 32'd42, "current_42");

    pulse(2, 23);
    rd(2, 3, 32'd2, "valid_set");
    rd(2, 2, 32'd23, "measured_23");
    rd(2, 3, 32'd0, "valid_cleared");
    pulse(2, 17);
    pulse(2, 9);
    rd(2, 3, 32'd6, "overrun_set");
    rd(2, 2, 32'd9, "measured_9");
    wr(2, 3, 32'd4);
    rd(2, 3, 32'd0, "overrun_cleared");

    rw(3, 0, 32'd40, 32'd10, "rw_prewrite");
    rd(3, 0, 32'd40, "rw_postwrite");

    settle();
    hi = int'(pwm_out[1]);
    fork
      begin
        repeat (PERIOD - 1) begin
          @(negedge clk);
          hi += int'(pwm_out[1]);
        end
      end
      begin
        repeat (3) @(negedge clk);
        wr(1, 3, 32'd0);
      end
    join
    check("disable_pulse_completes", hi, 32'd42);
    measure(1, hi); check("disabled_period", hi, 32'd0);

    settle();
    wr(1, 0, 32'd50);
    wr(1, 3, 32'd1);
    measure(1, hi); check("enable_snap_50", hi, 32'd50);
    check("model_w1_50", m_w[1], 32'd50);

    settle();
    repeat (4) @(negedge clk);
    check("pwm1_high_pre_reset", {31'b0, pwm_out[1]}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("pwm_drop_on_reset", {28'b0, pwm_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd(1, 0, 32'd10, "target1_after_reset");
    rd(1, 1, 32'd10, "current1_after_reset");
    rd(1, 3, 32'd0, "ctrl1_after_reset");
    rd(2, 2, 32'd0, "measured2_after_reset");
    rd(3, 0, 32'd10, "target3_after_reset");
    repeat (150) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
